mux_n_rr: RTL

Parametrised, registered N-to-1 channel multiplexer with valid/ready handshakes on every input and on the output. Each input channel is W bits wide. A per-cycle mode input picks the source either by explicit select, like the plain combinational 4:1 mux, or by fair round-robin arbitration among valid channels. The block sits between multiple producer channels and a single consumer and provides one cycle of registered latency at full throughput.

---
 rtl/mux_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mux_n_rr.sv | 114 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-to-1 channel multiplexer.
// Holds the source-selection mode type and its two values.
package mux_pkg;

  typedef logic mux_mode_t;

  localparam mux_mode_t MODE_FIXED = 1'b0;
  localparam mux_mode_t MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (mod N) wins.
// The pointer register is kept by the caller.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_valid
);

  logic [N-1:0]  rot;
  logic [SELW:0] sum;

  // Rotate requests so that bit 0 is channel ptr, find the first set bit, then undo the rotation
  always_comb begin
    rot         = N'({req, req} >> ptr);
    sum         = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && rot[i]) begin
        grant_valid = 1'b1;
        sum         = {1'b0, ptr} + (SELW+1)'(i);
      end
    end
    if (sum >= (SELW+1)'(N)) begin
      sum = sum - (SELW+1)'(N);
    end
    grant_idx = sum[SELW-1:0];
    grant     = grant_valid ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/mux_n_rr.sv
// Registered N-to-1 valid/ready multiplexer with fixed-select or round-robin source choice.
// One output register gives one cycle of latency at full throughput.
module mux_n_rr
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  mux_mode_t       mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  input  logic            out_ready
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;

  logic [N-1:0]    rr_grant;
  logic [SELW-1:0] rr_grant_idx;
  logic            rr_grant_valid;

  logic [N-1:0]    fix_grant;
  logic            fix_valid;

  logic [N-1:0]    grant;
  logic [SELW-1:0] grant_idx;
  logic            grant_valid;
  logic            load;
  logic [W-1:0]    grant_data;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_idx   (rr_grant_idx),
    .grant_valid (rr_grant_valid)
  );

  // An out-of-range sel matches no channel and therefore never grants
  always_comb begin
    fix_valid = 1'b0;
    fix_grant = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        fix_valid    = in_valid[k];
        fix_grant[k] = in_valid[k];
      end
    end
  end

  always_comb begin
    grant       = (mode == MODE_RR) ? rr_grant       : fix_grant;
    grant_idx   = (mode == MODE_RR) ? rr_grant_idx   : sel;
    grant_valid = (mode == MODE_RR) ? rr_grant_valid : fix_valid;
    load        = !out_valid_q || out_ready;
    in_ready    = (rst_n && load) ? grant : '0;
    grant_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        grant_data = in_data[k*W +: W];
      end
    end
  end

  // Data and channel hold their last values when a load finds nothing to grant
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
        if (mode == MODE_RR) begin
          ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
